// File: rtl/tpu_feeder_pkg.sv
// Shared types for the TPU operand feeder: FSM state encoding and the (a,b) operand pair.
// No logic; latency and backpressure are not applicable.
package tpu_feeder_pkg;

   localparam int FEEDER_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [FEEDER_DATA_W-1:0] a;
      logic [FEEDER_DATA_W-1:0] b;
   } pair_t;

endpackage

// File: rtl/tpu_operand_feeder_buffer.sv
// DEPTH-entry operand pair store: one synchronous write port and one asynchronous read port.
// Write lands on the next edge, read is combinational; storage is never reset.
module operand_buffer #(
   parameter int W      = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [W-1:0]      wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [W-1:0]      rd_dat
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/tpu_operand_feeder.sv
// Loads up to DEPTH (a,b) pairs, then streams them one per out_ready cycle onto the TPU inputs; can replay.
// First pair is valid the cycle after the final load handshake; out_ready=0 holds the current pair stable.
module tpu_operand_feeder
   import tpu_feeder_pkg::*;
#(
   parameter int DATA_W  = FEEDER_DATA_W,
   parameter int DEPTH   = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              restream,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_a,
   input  logic [DATA_W-1:0] load_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err_len
);

   localparam int ADDR_W = $clog2(DEPTH);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    len_q, wr_idx, rd_idx;
   logic                err_q;
   logic                start_ok, rs_ok, load_hs, load_last, rd_last;
   logic [2*DATA_W-1:0] rd_dat;

   assign start_ok  = start && (cfg_len != '0) && (cfg_len <= CNT_W'(DEPTH));
   assign rs_ok     = !start && restream && (len_q != '0);
   assign load_hs   = load_valid && load_ready;
   assign load_last = (wr_idx == len_q - CNT_W'(1));
   assign rd_last   = (rd_idx == len_q - CNT_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok)   state_d = LOAD;
            else if (rs_ok) state_d = STREAM;
         end
         LOAD:    if (load_hs && load_last)   state_d = STREAM;
         STREAM:  if (out_ready && rd_last)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load_ready = 1'b0;
      out_valid  = 1'b0;
      out_a      = '0;
      out_b      = '0;
      out_last   = 1'b0;
      busy       = (state_q != IDLE);
      done       = 1'b0;
      err_len    = err_q;
      case (state_q)
         LOAD: load_ready = 1'b1;
         STREAM: begin
            out_valid      = 1'b1;
            {out_a, out_b} = rd_dat;
            out_last       = rd_last;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Indices stop at len_q-1; the state change, not a wrap, ends each phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q  <= '0;
         wr_idx <= '0;
         rd_idx <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= (state_q == IDLE) &&
                  ((start && !start_ok) || (!start && restream && (len_q == '0)));
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  len_q  <= cfg_len;
                  wr_idx <= '0;
               end else if (rs_ok) begin
                  rd_idx <= '0;
               end
            end
            LOAD: begin
               if (load_hs) begin
                  if (load_last) rd_idx <= '0;
                  else           wr_idx <= wr_idx + CNT_W'(1);
               end
            end
            STREAM: if (out_ready && !rd_last) rd_idx <= rd_idx + CNT_W'(1);
            default: ;
         endcase
      end
   end

   operand_buffer #(
      .W      (2 * DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (load_hs),
      .wr_addr (wr_idx[ADDR_W-1:0]),
      .wr_dat  ({load_a, load_b}),
      .rd_addr (rd_idx[ADDR_W-1:0]),
      .rd_dat  (rd_dat)
   );

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Directed bench for tpu_operand_feeder: load/stream, backpressure, replay, length errors, reset abort.
module tb_tpu_operand_feeder;
   import tpu_feeder_pkg::*;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic              restream;
   logic [CNT_W-1:0]  cfg_len;
   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_a;
   logic [DATA_W-1:0] load_b;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              err_len;

   int    vectors     = 0;
   int    miscompares = 0;
   pair_t ld [DEPTH];

   tpu_operand_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .restream   (restream),
      .cfg_len    (cfg_len),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_a     (load_a),
      .load_b     (load_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err_len    (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a load of n pairs from ld[]; optional one-cycle valid gap before odd indices.
   task automatic do_load(input int n, input bit gaps, input bit with_rs);
      cfg_len  = CNT_W'(n);
      start    = 1'b1;
      restream = with_rs;
      step();
      start    = 1'b0;
      restream = 1'b0;
      chk("load_ready_on", load_ready, 1);
      chk("busy_load", busy, 1);
      chk("out_valid_load", out_valid, 0);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 2 == 1)) begin
            load_valid = 1'b0;
            step();
            chk("load_gap_hold", load_ready, 1);
         end
         load_valid = 1'b1;
         load_a     = ld[i].a;
         load_b     = ld[i].b;
         step();
      end
      load_valid = 1'b0;
      chk("load_ready_off", load_ready, 0);
   endtask

   // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1,0,0,...
   task automatic stream_check(input int n, input int mode, input bit poke_start);
      int k = 0;
      int c = 0;
      bit rdy;
      while (k < n && c < 64) begin
         chk("out_valid", out_valid, 1);
         chk("out_a", out_a, ld[k].a);
         chk("out_b", out_b, ld[k].b);
         chk("out_last", out_last, (k == n - 1));
         chk("load_ready_stream", load_ready, 0);
         rdy       = (mode == 0) || (c % 3 == 0);
         out_ready = rdy;
         start     = poke_start && (c == 1);
         cfg_len   = CNT_W'(2);
         step();
         start = 1'b0;
         if (rdy) k++;
         c++;
      end
      chk("stream_count", k, n);
      if (mode == 0) chk("stream_cycles", c, n);
      chk("done_pulse", done, 1);
      chk("out_valid_done", out_valid, 0);
      chk("out_a_done", out_a, 0);
      chk("out_last_done", out_last, 0);
      out_ready = 1'b1;
      step();
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      restream   = 1'b0;
      cfg_len    = '0;
      load_valid = 1'b0;
      load_a     = '0;
      load_b     = '0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_last", out_last, 0);
      reset_n = 1'b1;
      step();

      // Illegal lengths 0 and 9
      start = 1'b1; cfg_len = 4'd0;
      step();
      start = 1'b0;
      chk("err_len0", err_len, 1);
      chk("err_len0_busy", busy, 0);
      chk("err_len0_load_ready", load_ready, 0);
      step();
      chk("err_len0_clear", err_len, 0);
      start = 1'b1; cfg_len = 4'd9;
      step();
      start = 1'b0;
      chk("err_len9", err_len, 1);
      chk("err_len9_busy", busy, 0);
      chk("err_len9_load_ready", load_ready, 0);
      step();
      chk("err_len9_clear", err_len, 0);

      // Four pairs, free-running consumer
      ld[0] = '{a: 16'd1, b: 16'd2};
      ld[1] = '{a: 16'd3, b: 16'd4};
      ld[2] = '{a: 16'd5, b: 16'd6};
      ld[3] = '{a: 16'd7, b: 16'd8};
      do_load(4, 1'b0, 1'b0);
      stream_check(4, 0, 1'b0);

      // Replay without reload; a start during replay is ignored
      restream = 1'b1;
      step();
      restream = 1'b0;
      chk("replay_no_err", err_len, 0);
      stream_check(4, 0, 1'b1);
      chk("replay_start_ignored", busy, 0);

      // Same vector with backpressure
      do_load(4, 1'b0, 1'b0);
      stream_check(4, 1, 1'b0);

      // Full depth with load gaps
      for (int i = 0; i < DEPTH; i++) begin
         ld[i].a = 16'h0100 + 16'(i);
         ld[i].b = 16'h0B00 + 16'(i);
      end
      do_load(8, 1'b1, 1'b0);
      stream_check(8, 0, 1'b0);

      // start and restream together: start wins
      ld[0] = '{a: 16'hAAAA, b: 16'h5555};
      ld[1] = '{a: 16'h1234, b: 16'hFEDC};
      do_load(2, 1'b0, 1'b1);
      stream_check(2, 0, 1'b0);

      // Reset mid-STREAM aborts at once; a following restream is rejected
      do_load(3, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      chk("pre_abort_out_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_a", out_a, 0);
      chk("abort_out_last", out_last, 0);
      step();
      reset_n = 1'b1;
      step();
      restream = 1'b1;
      step();
      restream = 1'b0;
      chk("abort_restream_err", err_len, 1);
      chk("abort_restream_busy", busy, 0);
      chk("abort_restream_valid", out_valid, 0);
      step();
      chk("abort_err_clear", err_len, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
